// File: rtl/apb_timer_pkg.sv
// Shared register map, CTRL field positions and the address-decode helper
// for the APB timer.
package apb_timer_pkg;

  localparam logic [3:0] OFS_CTRL   = 4'h0;
  localparam logic [3:0] OFS_LOAD   = 4'h4;
  localparam logic [3:0] OFS_VALUE  = 4'h8;
  localparam logic [3:0] OFS_STATUS = 4'hC;

  localparam int CTRL_EN           = 0;
  localparam int CTRL_RELOAD       = 1;
  localparam int CTRL_IRQ_EN       = 2;
  localparam int CTRL_PRESCALE_LSB = 8;
  localparam int STATUS_TIMEOUT    = 0;

  typedef enum logic [1:0] {
    SEL_CTRL   = 2'd0,
    SEL_LOAD   = 2'd1,
    SEL_VALUE  = 2'd2,
    SEL_STATUS = 2'd3
  } reg_sel_e;

  // Only the word index selects a register; byte lane and upper address bits
  // are the upstream decoder's business.
  function automatic reg_sel_e decode_sel(input logic [1:0] word);
    case ({word, 2'b00})
      OFS_LOAD:   return SEL_LOAD;
      OFS_VALUE:  return SEL_VALUE;
      OFS_STATUS: return SEL_STATUS;
      default:    return SEL_CTRL;
    endcase
  endfunction

endpackage

// File: rtl/apb_timer_prescaler.sv
// Prescaler for the APB timer: counts 0..prescale while enabled and emits a
// single-cycle tick on the terminal count, then wraps.
module apb_timer_prescaler #(
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  clr,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] cnt;

  // >= rather than == so lowering PRESCALE mid-count ticks at once instead
  // of wrapping through the whole counter range.
  assign tick = en && (cnt >= prescale);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + PRESCALE_W'(1);
    end
  end

endmodule

// File: rtl/apb_timer.sv
// APB slave wrapping a 32-bit down-counting timer with prescaler, optional
// auto-reload and a sticky, maskable timeout interrupt.
module apb_timer
  import apb_timer_pkg::*;
#(
  parameter int PRESCALE_W = 8,
  parameter int COUNT_W    = 32
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        IRQ
);

  // Bus handshake: no PREADY, every transfer is zero-wait. A write commits on
  // the access cycle (PSEL & PENABLE & PWRITE); a read captures PRDATA on the
  // setup cycle (PSEL & !PENABLE & !PWRITE) and holds it until the next one.
  reg_sel_e               sel;
  logic                   wr_en, rd_setup;
  logic                   wr_ctrl, wr_load, wr_status;
  logic                   ctrl_en, ctrl_reload, ctrl_irq_en;
  logic [PRESCALE_W-1:0]  ctrl_prescale;
  logic [COUNT_W-1:0]     load_q, value_q;
  logic                   timeout_q;
  logic                   tick, expire, pre_clr;
  logic [31:0]            rdata;
  logic                   unused_paddr;

  assign unused_paddr = ^{PADDR[31:4], PADDR[1:0]};

  assign sel       = decode_sel(PADDR[3:2]);
  assign wr_en     = PSEL && PENABLE && PWRITE;
  assign rd_setup  = PSEL && !PENABLE && !PWRITE;
  assign wr_ctrl   = wr_en && (sel == SEL_CTRL);
  assign wr_load   = wr_en && (sel == SEL_LOAD);
  assign wr_status = wr_en && (sel == SEL_STATUS);
  assign expire    = tick && (value_q == '0);
  assign pre_clr   = wr_load || (wr_ctrl && PWDATA[CTRL_EN] && !ctrl_en);

  apb_timer_prescaler #(.PRESCALE_W(PRESCALE_W)) u_prescaler (
    .clk      (HCLK),
    .rst_n    (HRESETn),
    .en       (ctrl_en),
    .clr      (pre_clr),
    .prescale (ctrl_prescale),
    .tick     (tick)
  );

  // A CTRL write outranks the one-shot auto-clear of EN in the same cycle.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      ctrl_en       <= 1'b0;
      ctrl_reload   <= 1'b0;
      ctrl_irq_en   <= 1'b0;
      ctrl_prescale <= '0;
    end else if (wr_ctrl) begin
      ctrl_en       <= PWDATA[CTRL_EN];
      ctrl_reload   <= PWDATA[CTRL_RELOAD];
      ctrl_irq_en   <= PWDATA[CTRL_IRQ_EN];
      ctrl_prescale <= PWDATA[CTRL_PRESCALE_LSB +: PRESCALE_W];
    end else if (expire && !ctrl_reload) begin
      ctrl_en <= 1'b0;
    end
  end

  // A LOAD write outranks a same-cycle decrement or reload.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      load_q  <= '0;
      value_q <= '0;
    end else if (wr_load) begin
      load_q  <= PWDATA[COUNT_W-1:0];
      value_q <= PWDATA[COUNT_W-1:0];
    end else if (tick) begin
      if (value_q != '0) begin
        value_q <= value_q - COUNT_W'(1);
      end else if (ctrl_reload) begin
        value_q <= load_q;
      end
    end
  end

  // Hardware set wins over a same-cycle write-1-to-clear.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      timeout_q <= 1'b0;
      IRQ       <= 1'b0;
    end else begin
      if (expire) begin
        timeout_q <= 1'b1;
      end else if (wr_status && PWDATA[STATUS_TIMEOUT]) begin
        timeout_q <= 1'b0;
      end
      IRQ <= timeout_q && ctrl_irq_en;
    end
  end

  always_comb begin
    rdata = '0;
    case (sel)
      SEL_CTRL: begin
        rdata[CTRL_EN]     = ctrl_en;
        rdata[CTRL_RELOAD] = ctrl_reload;
        rdata[CTRL_IRQ_EN] = ctrl_irq_en;
        rdata[CTRL_PRESCALE_LSB +: PRESCALE_W] = ctrl_prescale;
      end
      SEL_LOAD:   rdata[COUNT_W-1:0]    = load_q;
      SEL_VALUE:  rdata[COUNT_W-1:0]    = value_q;
      SEL_STATUS: rdata[STATUS_TIMEOUT] = timeout_q;
      default:    rdata = '0;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      PRDATA <= '0;
    end else if (rd_setup) begin
      PRDATA <= rdata;
    end
  end

endmodule
